// File: rtl/isa_pkg.sv
// Shared ISA definitions for the 16-bit pipeline: opcodes, instruction field
// positions, immediate sign extension and the ID/EX bubble value.
package isa_pkg;

  localparam int NREG = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_LW   = 4'h6;
  localparam logic [3:0] OP_SW   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;

  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RA_MSB = 11;
  localparam int RA_LSB = 8;
  localparam int RB_MSB = 7;
  localparam int RB_LSB = 4;
  localparam int RC_MSB = 3;
  localparam int RC_LSB = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        wr_en;
    logic        mem_rd;
    logic        mem_wr;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

  function automatic logic [15:0] sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

  function automatic logic [15:0] sext12(input logic [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline payload bundle: the decode stage drives it (master), the
// execute stage consumes it (slave).
interface id_stage_if;
  logic [3:0]  idex_op;
  logic [3:0]  idex_rd;
  logic [15:0] idex_a;
  logic [15:0] idex_b;
  logic [15:0] idex_imm;
  logic [15:0] idex_pc;
  logic        idex_wr_en;
  logic        idex_mem_rd;
  logic        idex_mem_wr;

  modport master (
    output idex_op, idex_rd, idex_a, idex_b, idex_imm, idex_pc,
           idex_wr_en, idex_mem_rd, idex_mem_wr
  );

  modport slave (
    input idex_op, idex_rd, idex_a, idex_b, idex_imm, idex_pc,
          idex_wr_en, idex_mem_rd, idex_mem_wr
  );
endinterface

// File: rtl/id_stage_regfile16.sv
// regfile16: 16x16 register file, two asynchronous read ports, one synchronous
// write port. R0 is hard zero. ID_WB_BYPASS_EN forwards the write data to reads.
module regfile16 #(
  parameter int NREG = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0][3:0]  rd_addr,
  output logic [1:0][15:0] rd_data,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [15:0]      wr_data
);

  logic [15:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && wr_addr != 4'd0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic hit;
`ifdef ID_WB_BYPASS_EN
      assign hit = wr_en && (wr_addr == rd_addr[gi]);
`else
      assign hit = 1'b0;
`endif
      assign rd_data[gi] = (rd_addr[gi] == 4'd0) ? 16'd0 :
                           hit                   ? wr_data :
                                                   mem[rd_addr[gi]];
    end
  endgenerate

endmodule

// File: rtl/id_stage.sv
// id_stage: decode, register read, branch/jump resolution and hazard detection,
// registering into ID/EX. Optional feature macro: ID_WB_BYPASS_EN.
import isa_pkg::*;

module id_stage #(
  parameter int NREG = isa_pkg::NREG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_in,
  input  logic [15:0] pc_in,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic        mem_wr_en,
  input  logic [3:0]  mem_rd,
  output logic        pc_enable,
  output logic        if_id_hold,
  output logic        flush,
  output logic        branch_selector,
  output logic [15:0] jmp_result,
  id_stage_if.master  idex,
  output logic        illegal
);

  logic [3:0] op, ra, rb, rc;
  assign op = inst_in[OP_MSB:OP_LSB];
  assign ra = inst_in[RA_MSB:RA_LSB];
  assign rb = inst_in[RB_MSB:RB_LSB];
  assign rc = inst_in[RC_MSB:RC_LSB];

  logic       use_1, use_2, is_illegal, is_beq, is_jmp;
  logic [3:0] src_2;

  // Port 0 always reads rb; port 1 reads rc for ALU ops and ra otherwise.
  always_comb begin
    use_1      = 1'b0;
    use_2      = 1'b0;
    src_2      = ra;
    is_illegal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        use_1 = 1'b1;
        use_2 = 1'b1;
        src_2 = rc;
      end
      OP_ADDI, OP_LW: use_1 = 1'b1;
      OP_SW, OP_BEQ: begin
        use_1 = 1'b1;
        use_2 = 1'b1;
      end
      OP_NOP, OP_JMP: ;
      default: is_illegal = 1'b1;
    endcase
  end

  assign is_beq = (op == OP_BEQ);
  assign is_jmp = (op == OP_JMP);

  logic [1:0][3:0]  rd_addr;
  logic [1:0][15:0] rd_data;
  assign rd_addr = {src_2, rb};

  regfile16 #(.NREG(NREG)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data)
  );

  idex_t dec;

  always_comb begin
    dec = IDEX_BUBBLE;
    if (op != OP_NOP && !is_illegal) begin
      dec.op = op;
      dec.pc = pc_in;
      if (use_1) dec.a = rd_data[0];
      if (use_2) dec.b = rd_data[1];
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          dec.rd    = ra;
          dec.wr_en = 1'b1;
        end
        OP_ADDI: begin
          dec.rd    = ra;
          dec.wr_en = 1'b1;
          dec.imm   = sext4(rc);
        end
        OP_LW: begin
          dec.rd     = ra;
          dec.wr_en  = 1'b1;
          dec.mem_rd = 1'b1;
          dec.imm    = sext4(rc);
        end
        OP_SW: begin
          dec.mem_wr = 1'b1;
          dec.imm    = sext4(rc);
        end
        OP_BEQ:  dec.imm = sext4(rc);
        OP_JMP:  dec.imm = sext12(inst_in[11:0]);
        default: ;
      endcase
    end
  end

  function automatic logic src_hit(input logic [3:0] r, input logic u1, input logic u2,
                                   input logic [3:0] s1, input logic [3:0] s2);
    return (r != 4'd0) && ((u1 && s1 == r) || (u2 && s2 == r));
  endfunction

  idex_t idex_reg, idex_next;
  logic  illegal_reg;

  logic hit_ex, hit_mem, load_use, branch_stall, wb_stall, stall, taken;
  logic [15:0] target;

  assign hit_ex  = src_hit(idex_reg.rd, use_1, use_2, rb, src_2);
  assign hit_mem = src_hit(mem_rd, use_1, use_2, rb, src_2);

  assign load_use     = idex_reg.mem_rd && (idex_reg.rd != 4'd0) && hit_ex;
  assign branch_stall = is_beq && ((idex_reg.wr_en && hit_ex) || (mem_wr_en && hit_mem));

  // Without the bypass, a source being written back this cycle would read stale data.
`ifdef ID_WB_BYPASS_EN
  assign wb_stall = 1'b0;
`else
  assign wb_stall = wb_en && src_hit(wb_addr, use_1, use_2, rb, src_2);
`endif

  assign stall  = !rst && (load_use || branch_stall || wb_stall);
  assign taken  = !rst && !stall && (is_jmp || (is_beq && (rd_data[0] == rd_data[1])));
  assign target = pc_in + ((is_jmp ? sext12(inst_in[11:0]) : sext4(rc)) << 1);

  assign pc_enable       = !stall;
  assign if_id_hold      = stall;
  assign flush           = taken;
  assign branch_selector = taken;
  assign jmp_result      = taken ? target : 16'd0;

  always_comb begin
    idex_next = dec;
    if (stall) begin
      idex_next = IDEX_BUBBLE;
    end else if (taken) begin
      idex_next.wr_en  = 1'b0;
      idex_next.mem_rd = 1'b0;
      idex_next.mem_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_reg    <= IDEX_BUBBLE;
      illegal_reg <= 1'b0;
    end else begin
      idex_reg    <= idex_next;
      illegal_reg <= is_illegal;
    end
  end

  assign idex.idex_op     = idex_reg.op;
  assign idex.idex_rd     = idex_reg.rd;
  assign idex.idex_a      = idex_reg.a;
  assign idex.idex_b      = idex_reg.b;
  assign idex.idex_imm    = idex_reg.imm;
  assign idex.idex_pc     = idex_reg.pc;
  assign idex.idex_wr_en  = idex_reg.wr_en;
  assign idex.idex_mem_rd = idex_reg.mem_rd;
  assign idex.idex_mem_wr = idex_reg.mem_wr;
  assign illegal          = illegal_reg;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// instruction streams checked against an instruction-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inst_in, pc_in, wb_data, jmp_result;
  logic        wb_en, mem_wr_en;
  logic [3:0]  wb_addr, mem_rd;
  logic        pc_enable, if_id_hold, flush, branch_selector, illegal;

  always #5 clk = ~clk;

  id_stage_if idex_bus ();

  id_stage dut (
    .clk             (clk),
    .rst             (rst),
    .inst_in         (inst_in),
    .pc_in           (pc_in),
    .wb_en           (wb_en),
    .wb_addr         (wb_addr),
    .wb_data         (wb_data),
    .mem_wr_en       (mem_wr_en),
    .mem_rd          (mem_rd),
    .pc_enable       (pc_enable),
    .if_id_hold      (if_id_hold),
    .flush           (flush),
    .branch_selector (branch_selector),
    .jmp_result      (jmp_result),
    .idex            (idex_bus),
    .illegal         (illegal)
  );

  typedef struct {
    logic [3:0]  op, rd;
    logic [15:0] a, b, imm, pc;
    logic        wr, mrd, mwr, ill;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] regs_m [16];
  exp_t        m;
  logic        pipe_wr = 1'b0;
  logic [3:0]  pipe_rd = 4'd0;
  logic        last_stall, last_taken;
  logic        obs_pcen, obs_hold, obs_flush, obs_sel;
  logic [15:0] obs_jmp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t z;
    z.op = 0; z.rd = 0; z.a = 0; z.b = 0; z.imm = 0; z.pc = 0;
    z.wr = 0; z.mrd = 0; z.mwr = 0; z.ill = 0;
    return z;
  endfunction

  function automatic logic [15:0] rdv(input logic [3:0] r);
    if (r == 4'd0) return 16'd0;
`ifdef ID_WB_BYPASS_EN
    if (wb_en && wb_addr == r) return wb_data;
`endif
    return regs_m[r];
  endfunction

  // Instruction-level reference: what the stage must do with the current inputs.
  task automatic predict(output exp_t n, output logic st, output logic tk, output logic [15:0] jr);
    logic [3:0] op, ra, rb, rc;
    logic [3:0] srcs [$];
    int i4, i12;
    op = inst_in[15:12]; ra = inst_in[11:8]; rb = inst_in[7:4]; rc = inst_in[3:0];
    i4 = int'(rc);              if (i4 > 7)     i4 -= 16;
    i12 = int'(inst_in[11:0]);  if (i12 > 2047) i12 -= 4096;
    n = zero_exp();
    st = 1'b0; tk = 1'b0; jr = 16'd0;
    if (op >= 1 && op <= 4) srcs = '{rb, rc};
    else if (op == 5 || op == 6) srcs = '{rb};
    else if (op == 7 || op == 8) srcs = '{ra, rb};
    foreach (srcs[k]) begin
      if (srcs[k] != 0) begin
        if (m.mrd && m.rd == srcs[k]) st = 1'b1;
        if (op == 8 && ((m.wr && m.rd == srcs[k]) || (mem_wr_en && mem_rd == srcs[k]))) st = 1'b1;
`ifndef ID_WB_BYPASS_EN
        if (wb_en && wb_addr == srcs[k]) st = 1'b1;
`endif
      end
    end
    if (rst) begin
      st = 1'b0;
      return;
    end
    n.ill = (op >= 10);
    if (st || op == 0 || op >= 10) return;
    n.op = op;
    n.pc = pc_in;
    if (op <= 4) begin
      n.rd = ra; n.wr = 1; n.a = rdv(rb); n.b = rdv(rc);
    end else if (op == 5 || op == 6) begin
      n.rd = ra; n.wr = 1; n.mrd = (op == 6); n.a = rdv(rb); n.imm = 16'(i4);
    end else if (op == 7 || op == 8) begin
      n.mwr = (op == 7); n.a = rdv(rb); n.b = rdv(ra); n.imm = 16'(i4);
      if (op == 8 && rdv(ra) == rdv(rb)) begin
        tk = 1'b1; jr = 16'(int'(pc_in) + 2 * i4);
      end
    end else begin
      n.imm = 16'(i12);
      tk = 1'b1; jr = 16'(int'(pc_in) + 2 * i12);
    end
  endtask

  task automatic cycle(input string name);
    exp_t n;
    logic st, tk;
    logic [15:0] jr;
    predict(n, st, tk, jr);
    @(negedge clk);
    obs_pcen = pc_enable; obs_hold = if_id_hold; obs_flush = flush;
    obs_sel = branch_selector; obs_jmp = jmp_result;
    check({name, ".pc_enable"}, obs_pcen, !st);
    check({name, ".if_id_hold"}, obs_hold, st);
    check({name, ".flush"}, obs_flush, tk);
    check({name, ".branch_selector"}, obs_sel, tk);
    check({name, ".jmp_result"}, obs_jmp, jr);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 16; i++) regs_m[i] = 16'd0;
    end else if (wb_en && wb_addr != 0) begin
      regs_m[wb_addr] = wb_data;
    end
    pipe_wr = rst ? 1'b0 : m.wr;
    pipe_rd = rst ? 4'd0 : m.rd;
    m = n;
    last_stall = st;
    last_taken = tk;
    check({name, ".idex_op"}, idex_bus.idex_op, m.op);
    check({name, ".idex_rd"}, idex_bus.idex_rd, m.rd);
    check({name, ".idex_a"}, idex_bus.idex_a, m.a);
    check({name, ".idex_b"}, idex_bus.idex_b, m.b);
    check({name, ".idex_imm"}, idex_bus.idex_imm, m.imm);
    check({name, ".idex_pc"}, idex_bus.idex_pc, m.pc);
    check({name, ".idex_wr_en"}, idex_bus.idex_wr_en, m.wr);
    check({name, ".idex_mem_rd"}, idex_bus.idex_mem_rd, m.mrd);
    check({name, ".idex_mem_wr"}, idex_bus.idex_mem_wr, m.mwr);
    check({name, ".illegal"}, illegal, m.ill);
    $display("cyc %0d %s rst=%b inst=%h pc=%h wb=%b:%0d:%h pcen=%b sel=%b jmp=%h idex_op=%h a=%h b=%h",
             cyc, name, rst, inst_in, pc_in, wb_en, wb_addr, wb_data, obs_pcen, obs_sel,
             obs_jmp, idex_bus.idex_op, idex_bus.idex_a, idex_bus.idex_b);
    cyc++;
  endtask

  // EX/MEM inputs follow what the model says was in ID/EX one cycle earlier.
  task automatic set_in(input logic r, input logic [15:0] inst, input logic [15:0] pc,
                        input logic we, input logic [3:0] wa, input logic [15:0] wd);
    rst = r; inst_in = inst; pc_in = pc;
    wb_en = we; wb_addr = wa; wb_data = wd;
    mem_wr_en = pipe_wr; mem_rd = pipe_rd;
  endtask

  function automatic logic [15:0] rand_inst();
    logic [3:0] op, ra, rb, lo;
    op = 4'($urandom_range(0, 12));
    ra = 4'($urandom_range(0, 4));
    rb = 4'($urandom_range(0, 4));
    lo = (op >= 1 && op <= 4) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(0, 15));
    return {op, ra, rb, lo};
  endfunction

  initial begin
    m = zero_exp();
    for (int i = 0; i < 16; i++) regs_m[i] = 16'd0;
    set_in(1'b1, 16'h0000, 16'h0000, 1'b0, 4'd0, 16'h0000);
    @(posedge clk);
    #1;

    // Reset: a JMP presented during reset must not redirect.
    set_in(1'b1, 16'h9100, 16'h0040, 1'b0, 4'd0, 16'h0000);
    cycle("reset");
    check("reset.no_redirect", obs_sel, 1'b0);
    set_in(1'b0, 16'h0000, 16'h0000, 1'b0, 4'd0, 16'h0000);
    cycle("nop");
    check("nop.pc_enable_high", obs_pcen, 1'b1);

    // Writeback then ALU read.
    set_in(1'b0, 16'h0000, 16'h0002, 1'b1, 4'd3, 16'h1234);
    cycle("wb_r3");
    set_in(1'b0, 16'h1133, 16'h0004, 1'b0, 4'd0, 16'h0000);
    cycle("add");
    check("add.a_value", idex_bus.idex_a, 16'h1234);
    check("add.rd_value", idex_bus.idex_rd, 4'd1);

    // Load-use: one stall cycle then issue.
    set_in(1'b0, 16'h6201, 16'h0006, 1'b0, 4'd0, 16'h0000);
    cycle("lw");
    set_in(1'b0, 16'h1420, 16'h0008, 1'b0, 4'd0, 16'h0000);
    cycle("lu_stall");
    check("lu_stall.pc_held", obs_pcen, 1'b0);
    check("lu_stall.bubble_op", idex_bus.idex_op, 4'h0);
    cycle("lu_issue");
    check("lu_issue.op", idex_bus.idex_op, 4'h1);

    // Taken BEQ with a negative offset.
    set_in(1'b0, 16'h0000, 16'h000A, 1'b1, 4'd5, 16'h0007);
    cycle("wb_r5");
    set_in(1'b0, 16'h0000, 16'h000C, 1'b1, 4'd6, 16'h0007);
    cycle("wb_r6");
    set_in(1'b0, 16'h856E, 16'h0010, 1'b0, 4'd0, 16'h0000);
    cycle("beq");
    check("beq.target", obs_jmp, 16'h000C);
    check("beq.flush", obs_flush, 1'b1);

    // JMP wraps and ignores a pending LW.
    set_in(1'b0, 16'h6201, 16'h0012, 1'b0, 4'd0, 16'h0000);
    cycle("lw2");
    set_in(1'b0, 16'h9100, 16'hFF00, 1'b0, 4'd0, 16'h0000);
    cycle("jmp");
    check("jmp.target_wrap", obs_jmp, 16'h0100);
    check("jmp.no_stall", obs_pcen, 1'b1);

    // Illegal opcode.
    set_in(1'b0, 16'hB000, 16'h0100, 1'b0, 4'd0, 16'h0000);
    cycle("illegal");
    check("illegal.flag", illegal, 1'b1);
    check("illegal.wr_en", idex_bus.idex_wr_en, 1'b0);

    // Same-cycle writeback to a source register.
    set_in(1'b0, 16'h1170, 16'h0102, 1'b1, 4'd7, 16'hBEEF);
    cycle("wb_fwd");
`ifdef ID_WB_BYPASS_EN
    check("wb_fwd.no_stall", obs_pcen, 1'b1);
    check("wb_fwd.a_value", idex_bus.idex_a, 16'hBEEF);
`else
    check("wb_fwd.stall", obs_pcen, 1'b0);
    set_in(1'b0, 16'h1170, 16'h0102, 1'b0, 4'd0, 16'h0000);
    cycle("wb_retry");
    check("wb_retry.a_value", idex_bus.idex_a, 16'hBEEF);
`endif

    // Reset in the middle of a load-use stall.
    set_in(1'b0, 16'h6201, 16'h0104, 1'b0, 4'd0, 16'h0000);
    cycle("lw3");
    set_in(1'b1, 16'h1420, 16'h0106, 1'b0, 4'd0, 16'h0000);
    cycle("rst_mid");
    check("rst_mid.pc_enable", obs_pcen, 1'b1);
    set_in(1'b0, 16'h1420, 16'h0106, 1'b0, 4'd0, 16'h0000);
    cycle("after_rst");
    check("after_rst.no_stall", obs_pcen, 1'b1);

    // Random instruction stream with fetch-side hold/flush behaviour.
    for (int k = 0; k < 300; k++) begin
      logic [15:0] ni, np;
      ni = inst_in; np = pc_in;
      if (last_taken) begin
        ni = 16'h0000; np = 16'($urandom) & 16'hFFFE;
      end else if (!last_stall) begin
        ni = rand_inst(); np = 16'($urandom) & 16'hFFFE;
      end
      set_in(($urandom_range(0, 99) == 0), ni, np, 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 4)), 16'($urandom_range(0, 3)));
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 16-bit pipeline. Consumes the IF/ID buffer outputs (instruction, PC+2), reads a 16×16 register file, resolves branches and jumps in decode, detects load-use and branch-operand hazards, and registers the decoded operation into the ID/EX buffer. Drives `pc_enable`, `flush`, `branch_selector` and `jmp_result` back to the fetch datapath.

## Interface
- `NREG`, 16: register count; R0 reads 0, writes ignored.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_in` in 16: instruction from IF/ID buffer.
- `pc_in` in 16: PC+2 from IF/ID buffer.
- `wb_en` in 1: writeback enable.
- `wb_addr` in 4: writeback register.
- `wb_data` in 16: writeback value.
- `mem_wr_en` in 1: EX/MEM instruction writes a register.
- `mem_rd` in 4: EX/MEM destination.
- `pc_enable` out 1: 0 = hold PC.
- `if_id_hold` out 1: 1 = IF/ID keeps its contents.
- `flush` out 1: 1 = IF/ID loads NOP next edge.
- `branch_selector` out 1: 1 = PC loads `jmp_result`.
- `jmp_result` out 16: branch/jump target.
- `idex_op` out 4, `idex_rd` out 4, `idex_a` out 16, `idex_b` out 16, `idex_imm` out 16, `idex_pc` out 16: ID/EX payload.
- `idex_wr_en`, `idex_mem_rd`, `idex_mem_wr` out 1 each: ID/EX controls.
- `illegal` out 1: registered, opcode undefined.

## Operation
- Format: op=[15:12], ra=[11:8], rb=[7:4], rc/imm4=[3:0], imm12=[11:0].
- Opcodes: 0 NOP; 1 ADD ra←rb+rc; 2 SUB; 3 AND; 4 OR; 5 ADDI ra←rb+sext(imm4); 6 LW ra←M[rb+sext(imm4)]; 7 SW M[rb+sext(imm4)]←ra; 8 BEQ if ra==rb; 9 JMP; A–F illegal (decoded as NOP, `illegal`=1).
- Targets: BEQ = pc_in + (sext(imm4)<<1); JMP = pc_in + (sext(imm12)<<1); 16-bit wrap, carry discarded.
- Sources: ALU ops read rb, rc; ADDI/LW read rb; SW reads ra, rb; BEQ reads ra, rb. Reads of R0 never hazard.
- Load-use stall: ID/EX holds LW (`idex_mem_rd`=1, `idex_rd`≠0) and the current instruction sources `idex_rd`.
- Branch stall: BEQ source matches `idex_rd` with `idex_wr_en`=1, or matches `mem_rd` with `mem_wr_en`=1.
- Stall: `pc_enable`=0, `if_id_hold`=1, ID/EX loads a bubble (all controls 0, `idex_op`=0), `flush`=0, `branch_selector`=0.
- Redirect, no stall: JMP, or BEQ with equal operands → `branch_selector`=1, `flush`=1, `jmp_result`=target; the decoded op still enters ID/EX as a control-free bubble.
- Stall beats redirect; JMP never stalls. Not-taken BEQ: `jmp_result`=0, selector 0.
- Regfile write on rising edge when `wb_en` and `wb_addr`≠0.

## Timing
- Decode, hazard and redirect outputs are combinational from `inst_in`, `pc_in`, ID/EX state and `mem_*`.
- ID/EX registers and `illegal` update on the rising edge; one-cycle latency IF/ID→ID/EX.
- Reset: all ID/EX outputs and `illegal` 0; all registers 0; with `rst`=1, `pc_enable`=1, `if_id_hold`=0, `flush`=0, `branch_selector`=0, `jmp_result`=0. Reset mid-stall clears the stall source next edge.
- Load-use stall lasts exactly one cycle; branch stall lasts until the producer leaves EX/MEM (max 2 cycles).

## Configuration
- `ID_WB_BYPASS_EN` defined: a read of `wb_addr` while `wb_en`=1 returns `wb_data` the same cycle.
- Undefined: the read returns the old value; the hazard unit additionally stalls any instruction sourcing `wb_addr` while `wb_en`=1 (one cycle).

## Structure
- Shared package `isa_pkg`: opcode constants, field positions, `sext4`/`sext12` functions, ID/EX bubble value.
- One sub-module `regfile16` (2 async read ports + 1 ssync write port, bypass under the macro); hazard and decode logic inline.

## Test plan
- Reset, then `inst_in`=0x0000 → all ID/EX outputs 0, `pc_enable`=1, no flush.
- WB R3←0x1234, then ADD R1,R3,R3 (0x1133) → `idex_a`=`idex_b`=0x1234, `idex_rd`=1, `idex_wr_en`=1.
- LW R2,[R0+1] (0x6201) then ADD R4,R2,R0 (0x1420) → one stall cycle: `pc_enable`=0, `if_id_hold`=1, bubble in ID/EX, then ADD issues.
- R5=R6=7, BEQ R5,R6,-2 (0x856E), pc_in=0x0010 → `branch_selector`=1, `flush`=1, `jmp_result`=0x000C.
- JMP +0x100 (0x9100), pc_in=0xFF00 → `jmp_result`=0x0100 (wrap), no stall even with a pending LW in ID/EX.
- Opcode 0xB → `illegal`=1 next edge, ID/EX controls 0; with/without `ID_WB_BYPASS_EN`, same-cycle WB-to-read → value forwarded vs one stall cycle.
